// File: rtl/sprite_animator.sv
// Single-unit sprite producer: spawns, walks toward a target at a capped per-frame speed,
// cycles a walk animation, and publishes position and frame to graphics once per video frame.
module sprite_animator #(
  parameter int NUM_FRAMES      = 5,
  parameter int FRAMES_PER_STEP = 6,
  parameter int SPEED           = 2,
  parameter int SCREEN_W        = 1280,
  parameter int SCREEN_H        = 720,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic          clk_pixel,
  input  logic          sys_rst,
  input  logic          new_frame,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [10:0]   cmd_x,
  input  logic [9:0]    cmd_y,
  input  logic [10:0]   cmd_tx,
  input  logic [9:0]    cmd_ty,
  input  logic          kill,
  output logic          arrived,
  output logic          sprite_valid,
  output logic [10:0]   sprite_x,
  output logic [9:0]    sprite_y,
  output logic [FW-1:0] sprite_frame_number
);

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [10:0]   MAX_X   = 11'(SCREEN_W - 1);
  localparam logic [9:0]    MAX_Y   = 10'(SCREEN_H - 1);
  localparam logic [11:0]   SPD     = 12'(SPEED);
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAMES_PER_STEP - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_WALK, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [10:0]   r_pos_x;
  logic [9:0]    r_pos_y;
  logic [10:0]   r_tgt_x;
  logic [9:0]    r_tgt_y;
  logic [CW-1:0] r_anim_cnt;
  logic [FW-1:0] r_anim_frame;
  logic          r_sprite_valid;
  logic [10:0]   r_sprite_x;
  logic [9:0]    r_sprite_y;
  logic [FW-1:0] r_sprite_frame;
  logic          r_arrived;

  logic          w_cmd_ready;
  logic          w_accept;
  logic [10:0]   w_cmd_x_c;
  logic [9:0]    w_cmd_y_c;
  logic [10:0]   w_cmd_tx_c;
  logic [9:0]    w_cmd_ty_c;
  logic [11:0]   w_nx_full;
  logic [11:0]   w_ny_full;
  logic [10:0]   w_next_x;
  logic [9:0]    w_next_y;
  logic          w_arrive;
  logic          w_cnt_wrap;
  logic [CW-1:0] w_cnt_next;
  logic [FW-1:0] w_frame_next;
  logic          w_unused_hi;

  function automatic logic [10:0] clamp_x(input logic [10:0] v);
    return (v > MAX_X) ? MAX_X : v;
  endfunction

  function automatic logic [9:0] clamp_y(input logic [9:0] v);
    return (v > MAX_Y) ? MAX_Y : v;
  endfunction

  // Moves p toward t by at most SPD; the step is capped at |t-p| so it never overshoots.
  function automatic logic [11:0] step_axis(input logic [11:0] p, input logic [11:0] t);
    logic signed [11:0] diff;
    logic [11:0]        mag;
    logic [11:0]        stp;
    diff = $signed(t) - $signed(p);
    mag  = diff[11] ? $unsigned(-diff) : $unsigned(diff);
    stp  = (mag > SPD) ? SPD : mag;
    return diff[11] ? (p - stp) : (p + stp);
  endfunction

  assign w_cmd_x_c  = clamp_x(cmd_x);
  assign w_cmd_y_c  = clamp_y(cmd_y);
  assign w_cmd_tx_c = clamp_x(cmd_tx);
  assign w_cmd_ty_c = clamp_y(cmd_ty);

  assign w_nx_full   = step_axis({1'b0, r_pos_x}, {1'b0, r_tgt_x});
  assign w_ny_full   = step_axis({2'b0, r_pos_y}, {2'b0, r_tgt_y});
  assign w_next_x    = w_nx_full[10:0];
  assign w_next_y    = w_ny_full[9:0];
  assign w_unused_hi = ^{w_nx_full[11], w_ny_full[11:10]};
  assign w_arrive    = (w_next_x == r_tgt_x) && (w_next_y == r_tgt_y);

  assign w_cnt_wrap   = (r_anim_cnt == CNT_MAX);
  assign w_cnt_next   = w_cnt_wrap ? '0 : r_anim_cnt + CW'(1);
  assign w_frame_next = !w_cnt_wrap ? r_anim_frame :
                        (r_anim_frame == FRM_MAX) ? '0 : r_anim_frame + FW'(1);

  // Kill masks ready so a simultaneous command can never win over removal.
  assign w_cmd_ready = ((r_state == S_IDLE) || (r_state == S_HOLD)) && !kill;
  assign w_accept    = cmd_valid && w_cmd_ready;

  always_ff @(posedge clk_pixel) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SPAWN;
      S_SPAWN: begin
        if (kill)           w_state_nxt = S_IDLE;
        else if (new_frame) w_state_nxt = S_WALK;
      end
      S_WALK: begin
        if (kill)                       w_state_nxt = S_IDLE;
        else if (new_frame && w_arrive) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (kill)          w_state_nxt = S_IDLE;
        else if (w_accept) w_state_nxt = S_WALK;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      r_pos_x        <= '0;
      r_pos_y        <= '0;
      r_tgt_x        <= '0;
      r_tgt_y        <= '0;
      r_anim_cnt     <= '0;
      r_anim_frame   <= '0;
      r_sprite_valid <= 1'b0;
      r_sprite_x     <= '0;
      r_sprite_y     <= '0;
      r_sprite_frame <= '0;
      r_arrived      <= 1'b0;
    end else begin
      r_arrived <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (new_frame) r_sprite_valid <= 1'b0;
          if (w_accept) begin
            r_pos_x      <= w_cmd_x_c;
            r_pos_y      <= w_cmd_y_c;
            r_tgt_x      <= w_cmd_tx_c;
            r_tgt_y      <= w_cmd_ty_c;
            r_anim_cnt   <= '0;
            r_anim_frame <= '0;
          end
        end
        S_SPAWN: begin
          if (!kill && new_frame) begin
            r_sprite_valid <= 1'b1;
            r_sprite_x     <= r_pos_x;
            r_sprite_y     <= r_pos_y;
            r_sprite_frame <= '0;
          end
        end
        S_WALK: begin
          if (!kill && new_frame) begin
            r_pos_x        <= w_next_x;
            r_pos_y        <= w_next_y;
            r_sprite_valid <= 1'b1;
            r_sprite_x     <= w_next_x;
            r_sprite_y     <= w_next_y;
            if (w_arrive) begin
              r_anim_cnt     <= '0;
              r_anim_frame   <= '0;
              r_sprite_frame <= '0;
              r_arrived      <= 1'b1;
            end else begin
              r_anim_cnt     <= w_cnt_next;
              r_anim_frame   <= w_frame_next;
              r_sprite_frame <= w_frame_next;
            end
          end
        end
        S_HOLD: begin
          // Publishing uses the pre-command state; a same-cycle retarget moves on the next frame.
          if (!kill && new_frame) begin
            r_sprite_valid <= 1'b1;
            r_sprite_x     <= r_pos_x;
            r_sprite_y     <= r_pos_y;
            r_sprite_frame <= '0;
          end
          if (w_accept) begin
            r_tgt_x <= w_cmd_tx_c;
            r_tgt_y <= w_cmd_ty_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready           = w_cmd_ready;
  assign arrived             = r_arrived;
  assign sprite_valid        = r_sprite_valid;
  assign sprite_x            = r_sprite_x;
  assign sprite_y            = r_sprite_y;
  assign sprite_frame_number = r_sprite_frame;

endmodule
